rv32_mmio_bridge: RTL and testbench

- Parametrised MMIO bridge between the core's load/store port and NUM_CH memory-mapped peripheral channels.
- Decodes the MMIO window and selects a channel from address bits.
- Carries one outstanding transaction at a time with a valid/ack handshake, a per-transaction timeout, and error responses for bad accesses.
- Sits beside data memory in the MEM stage. The core stalls MEM from request accept until rsp_valid.

---
 rtl/rv32_mmio_bridge.sv | 127 ++++++++++++
 tb/tb_rv32_mmio_bridge.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_mmio_bridge.sv
// rv32_mmio_bridge: single-outstanding MMIO bridge from the core load/store port to NUM_CH peripheral channels
module rv32_mmio_bridge #(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter logic [3:0] MMIO_TAG = 4'hF,
  parameter int         NUM_CH   = 4,
  parameter int         CH_LSB   = 16,
  parameter int         TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_we,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/8-1:0]      req_be,
  output logic                     is_mmio,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [NUM_CH-1:0]        dev_valid,
  output logic [ADDR_W-1:0]        dev_addr,
  output logic                     dev_we,
  output logic [DATA_W-1:0]        dev_wdata,
  output logic [DATA_W/8-1:0]      dev_be,
  input  logic [NUM_CH-1:0]        dev_ack,
  input  logic [NUM_CH*DATA_W-1:0] dev_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int CH_W = $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP_OK, RESP_ERR} state_e;
  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0] dev_valid_q, dev_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept, bad, hit;
  logic [CH_W-1:0]   req_ch;
  assign is_mmio   = req_addr[ADDR_W-1 -: 4] == MMIO_TAG;
  assign req_ready = state_q == IDLE;
  assign accept    = req_valid && req_ready;
  assign bad       = !is_mmio || req_addr[1:0] != 2'b00;
  assign req_ch    = req_addr[CH_LSB +: CH_W];
  assign hit       = dev_ack[ch_q];
  assign dev_valid = dev_valid_q;
  assign dev_addr  = addr_q;
  assign dev_we    = we_q;
  assign dev_wdata = wdata_q;
  assign dev_be    = be_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;
  // next state: latch on accept, hold dev_valid until ack or timeout, one-cycle response strobe
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = state_q == ISSUE ? cnt_q + 16'd1 : 16'd0;
    dev_valid_d = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = '0;
    case (state_q)
      IDLE: if (accept) begin
        ch_d        = req_ch;
        addr_d      = req_addr;
        we_d        = req_we;
        wdata_d     = req_wdata;
        be_d        = req_be;
        state_d     = bad ? RESP_ERR : ISSUE;
        rsp_valid_d = bad;
        rsp_err_d   = bad;
        dev_valid_d = bad ? '0 : NUM_CH'(1) << req_ch;
      end
      ISSUE: if (hit) begin
        state_d     = RESP_OK;
        rsp_valid_d = 1'b1;
        rdata_d     = we_q ? '0 : dev_rdata[ch_q*DATA_W +: DATA_W];
      end else if (cnt_q == 16'(TIMEOUT - 1)) begin
        state_d     = RESP_ERR;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end else begin
        dev_valid_d = dev_valid_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      dev_valid_q <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      dev_valid_q <= dev_valid_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_rv32_mmio_bridge.sv
// tb_rv32_mmio_bridge: directed and randomized checks of rv32_mmio_bridge against a transaction-level model
module tb_rv32_mmio_bridge;
  localparam int TO = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         req_we = 1'b0;
  logic [31:0]  req_wdata = '0;
  logic [3:0]   req_be = '0;
  logic         is_mmio;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   dev_valid;
  logic [31:0]  dev_addr;
  logic         dev_we;
  logic [31:0]  dev_wdata;
  logic [3:0]   dev_be;
  logic [3:0]   dev_ack = '0;
  logic [127:0] dev_rdata = '0;
  int checks = 0;
  int errors = 0;

  rv32_mmio_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be), .is_mmio(is_mmio),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dev_valid(dev_valid), .dev_addr(dev_addr), .dev_we(dev_we),
    .dev_wdata(dev_wdata), .dev_be(dev_be), .dev_ack(dev_ack), .dev_rdata(dev_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int rsp_cnt; logic err; logic [31:0] rdata;
    int dv_first; int dv_last; int dv_cnt; logic [3:0] dv_or;
    logic ready_after; logic mmio;
    logic [31:0] d_addr; logic d_we; logic [31:0] d_wdata; logic [3:0] d_be;
  } res_t;

  res_t o, e;
  logic [31:0] ackd;

  // Transaction-level model: what the core and device bus should see for one request
  function automatic res_t predict(logic [31:0] addr, logic we, logic [31:0] wd, logic [3:0] be, int k, logic [31:0] d);
    res_t r = '{default: 0};
    r.mmio = addr[31:28] == 4'hF;
    r.rsp_cnt = 1;
    r.ready_after = 1'b1;
    r.d_addr = addr; r.d_we = we; r.d_wdata = wd; r.d_be = be;
    if (!r.mmio || addr[1:0] != 2'b00) begin
      r.lat = 1; r.err = 1'b1;
    end else begin
      r.dv_or = 4'b0001 << addr[17:16];
      r.dv_first = 1;
      if (k >= 1 && k <= TO) begin
        r.lat = k + 1; r.rdata = we ? 32'h0 : d; r.dv_last = k;
      end else begin
        r.lat = TO + 1; r.err = 1'b1; r.dv_last = TO;
      end
      r.dv_cnt = r.dv_last;
    end
    return r;
  endfunction

  // Present one request at the current negedge, act as the device (ack at cycle k, 0 = never), record what was seen
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd, input logic [3:0] be, input int k, input bit wrong);
    logic [3:0] oh;
    oh = 4'b0001 << addr[17:16];
    o = '{default: 0};
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wd; req_be = be;
    #1 o.mmio = is_mmio;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    for (int n = 1; n <= TO + 4; n++) begin
      if (rsp_valid) begin
        o.rsp_cnt++;
        if (o.lat == 0) begin o.lat = n; o.err = rsp_err; o.rdata = rsp_rdata; end
      end
      if (o.lat != 0 && n == o.lat + 1) o.ready_after = req_ready;
      if (dev_valid != 4'b0) begin
        if (o.dv_first == 0) o.dv_first = n;
        o.dv_last = n; o.dv_cnt++; o.dv_or |= dev_valid;
      end
      if (n == 1) begin o.d_addr = dev_addr; o.d_we = dev_we; o.d_wdata = dev_wdata; o.d_be = dev_be; end
      dev_rdata = {$urandom, $urandom, $urandom, $urandom};
      dev_ack = wrong ? 4'($urandom) & ~oh : 4'b0;
      if (n == k) begin dev_ack |= oh; ackd = dev_rdata[addr[17:16]*32 +: 32]; end
      @(negedge clk);
    end
    dev_ack = 4'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (dev_valid !== 4'b0) begin errors++; $display("FAIL reset_dev_valid got %b exp 0000", dev_valid); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp got v%b e%b exp v0 e0", rsp_valid, rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %0h exp 0", rsp_rdata); end
    checks++; if ({dev_addr, dev_we, dev_wdata, dev_be} !== 69'h0) begin errors++; $display("FAIL reset_dev_bus got a%0h w%b d%0h b%0h exp 0", dev_addr, dev_we, dev_wdata, dev_be); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_hit();
    run_txn(32'hF002_0000, 1'b0, 32'h0, 4'hF, 3, 1'b0);
    checks++; if (o.lat !== 4) begin errors++; $display("FAIL load_lat got %0d exp 4", o.lat); end
    checks++; if (o.err !== 1'b0 || o.rdata !== ackd) begin errors++; $display("FAIL load_rsp got e%b %0h exp e0 %0h", o.err, o.rdata, ackd); end
    checks++; if (o.dv_or !== 4'b0100 || o.dv_first !== 1 || o.dv_last !== 3 || o.dv_cnt !== 3) begin errors++; $display("FAIL load_dev_valid got %b %0d..%0d n%0d exp 0100 1..3 n3", o.dv_or, o.dv_first, o.dv_last, o.dv_cnt); end
  endtask

  task automatic test_store_imm();
    run_txn(32'hF001_0004, 1'b1, 32'hCAFE_F00D, 4'hF, 1, 1'b0);
    checks++; if (o.d_we !== 1'b1 || o.d_wdata !== 32'hCAFE_F00D || o.d_addr !== 32'hF001_0004 || o.d_be !== 4'hF) begin errors++; $display("FAIL store_latch got we%b d%0h a%0h b%0h exp we1 dcafef00d af0010004 bf", o.d_we, o.d_wdata, o.d_addr, o.d_be); end
    checks++; if (o.lat !== 2 || o.err !== 1'b0 || o.rdata !== 32'h0) begin errors++; $display("FAIL store_rsp got lat%0d e%b %0h exp lat2 e0 0", o.lat, o.err, o.rdata); end
    checks++; if (o.ready_after !== 1'b1) begin errors++; $display("FAIL store_ready_t3 got %b exp 1", o.ready_after); end
  endtask

  task automatic test_errors();
    logic [31:0] bad_addr [2] = '{32'h8000_0000, 32'hF000_0002};
    logic [1:0]  exp_mmio = 2'b10;
    for (int i = 0; i < 2; i++) begin
      run_txn(bad_addr[i], 1'b0, 32'h0, 4'hF, 1, 1'b1);
      checks++; if (o.mmio !== exp_mmio[i]) begin errors++; $display("FAIL err%0d_is_mmio got %b exp %b", i, o.mmio, exp_mmio[i]); end
      checks++; if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.rsp_cnt !== 1) begin errors++; $display("FAIL err%0d_rsp got lat%0d e%b %0h n%0d exp lat1 e1 0 n1", i, o.lat, o.err, o.rdata, o.rsp_cnt); end
      checks++; if (o.dv_cnt !== 0) begin errors++; $display("FAIL err%0d_dev_valid got %0d cycles exp 0", i, o.dv_cnt); end
    end
  endtask

  task automatic test_timeout();
    run_txn(32'hF000_0000, 1'b0, 32'h0, 4'hF, TO + 2, 1'b0);
    checks++; if (o.lat !== TO + 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin errors++; $display("FAIL timeout_rsp got lat%0d e%b %0h exp lat%0d e1 0", o.lat, o.err, o.rdata, TO + 1); end
    checks++; if (o.dv_or !== 4'b0001 || o.dv_first !== 1 || o.dv_last !== TO) begin errors++; $display("FAIL timeout_dev_valid got %b %0d..%0d exp 0001 1..%0d", o.dv_or, o.dv_first, o.dv_last, TO); end
    checks++; if (o.rsp_cnt !== 1) begin errors++; $display("FAIL timeout_late_ack got %0d responses exp 1", o.rsp_cnt); end
  endtask

  task automatic test_ack_at_timeout();
    run_txn(32'hF003_0008, 1'b0, 32'h0, 4'hF, TO, 1'b1);
    checks++; if (o.lat !== TO + 1 || o.err !== 1'b0 || o.rdata !== ackd) begin errors++; $display("FAIL ack_at_timeout got lat%0d e%b %0h exp lat%0d e0 %0h", o.lat, o.err, o.rdata, TO + 1, ackd); end
    checks++; if (o.dv_or !== 4'b1000 || o.dv_cnt !== TO) begin errors++; $display("FAIL ack_at_timeout_dev got %b n%0d exp 1000 n%0d", o.dv_or, o.dv_cnt, TO); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    req_valid = 1'b1; req_addr = 32'hF000_0000; req_we = 1'b0;
    @(posedge clk);
    @(negedge clk) req_valid = 1'b0;
    seen |= rsp_valid;
    @(negedge clk) rst_n = 1'b0;
    seen |= rsp_valid;
    @(negedge clk);
    checks++; if (dev_valid !== 4'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_state got dv%b rdy%b exp dv0000 rdy1", dev_valid, req_ready); end
    rst_n = 1'b1;
    repeat (TO + 2) begin seen |= rsp_valid; @(negedge clk); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_rsp got %b exp 0", seen); end
    run_txn(32'hF001_0010, 1'b0, 32'h0, 4'h3, 2, 1'b0);
    checks++; if (o.lat !== 3 || o.err !== 1'b0 || o.rdata !== ackd) begin errors++; $display("FAIL reset_mid_after got lat%0d e%b %0h exp lat3 e0 %0h", o.lat, o.err, o.rdata, ackd); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic we;
    logic [3:0] be;
    int k;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[31:28] = 4'hF;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      we = 1'($urandom); wd = $urandom; be = 4'($urandom);
      k = $urandom_range(0, TO + 2);
      run_txn(a, we, wd, be, k, 1'($urandom));
      e = predict(a, we, wd, be, k, ackd);
      checks++; if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata || o.rsp_cnt !== e.rsp_cnt) begin errors++; $display("FAIL rand%0d_rsp a%0h k%0d got lat%0d e%b %0h n%0d exp lat%0d e%b %0h n%0d", i, a, k, o.lat, o.err, o.rdata, o.rsp_cnt, e.lat, e.err, e.rdata, e.rsp_cnt); end
      checks++; if (o.dv_or !== e.dv_or || o.dv_first !== e.dv_first || o.dv_last !== e.dv_last || o.dv_cnt !== e.dv_cnt) begin errors++; $display("FAIL rand%0d_dev_valid a%0h got %b %0d..%0d n%0d exp %b %0d..%0d n%0d", i, a, o.dv_or, o.dv_first, o.dv_last, o.dv_cnt, e.dv_or, e.dv_first, e.dv_last, e.dv_cnt); end
      checks++; if (o.mmio !== e.mmio || o.ready_after !== e.ready_after) begin errors++; $display("FAIL rand%0d_decode a%0h got m%b r%b exp m%b r%b", i, a, o.mmio, o.ready_after, e.mmio, e.ready_after); end
      checks++; if (o.d_addr !== e.d_addr || o.d_we !== e.d_we || o.d_wdata !== e.d_wdata || o.d_be !== e.d_be) begin errors++; $display("FAIL rand%0d_latch got a%0h w%b d%0h b%0h exp a%0h w%b d%0h b%0h", i, o.d_addr, o.d_we, o.d_wdata, o.d_be, e.d_addr, e.d_we, e.d_wdata, e.d_be); end
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_store_imm();
    test_errors();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
